// File: rtl/dma_block_controller_if.sv
// dma_block_controller_if: CPU command, bus arbitration and device
// handshake bundle for the DMA block controller.
interface dma_block_controller_if;
    logic        cmd_valid;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_length;
    logic        BR;
    logic        BG;
    logic        dev_req;
    logic        dev_valid;
    logic [63:0] dev_data;
    logic        busy;
    logic        dma_end;
    logic        dma_err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_length, BG, dev_valid, dev_data,
        output BR, dev_req, busy, dma_end, dma_err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_length, BG, dev_valid, dev_data,
        input  BR, dev_req, busy, dma_end, dma_err
    );
endinterface

// File: rtl/dma_block_controller.sv
// dma_block_controller: bus-master DMA moving device blocks into D-memory.
// Define DMA_CYCLE_STEAL_EN to release the bus for one cycle between blocks.
module dma_block_controller #(
    parameter int MEM_LAT     = 4,
    parameter int DEV_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    dma_block_controller_if.master bus,
    output logic                   writeM,
    output wire  [15:0]            addressM,
    inout  wire  [63:0]            dataM
);
    typedef enum logic [2:0] {
        IDLE, REQ, FETCH, WRITE, NEXT, DONE, REL
    } state_t;

    localparam logic [15:0] LAT_LAST = 16'(MEM_LAT - 1);
    localparam logic [15:0] TO_LAST  = 16'(DEV_TIMEOUT - 1);
    localparam bit          TO_EN    = (DEV_TIMEOUT != 0);

    state_t      state;
    state_t      stateNext;
    logic [15:0] addr;
    logic [16:0] remain;
    logic [15:0] cnt;
    logic [63:0] block;
    logic        errFlag;
    logic        brQ;
    logic [16:0] cmdBlocks;
    logic        grant;
    logic        own;
    logic        timeout;
    logic        lastLat;

    assign cmdBlocks = ({1'b0, bus.cmd_length} + 17'd3) >> 2;
    assign grant     = bus.BG;
    assign own       = grant && (state == WRITE);
    assign timeout   = TO_EN && (cnt == TO_LAST);
    assign lastLat   = (cnt == LAT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:  if (bus.cmd_valid)
                       stateNext = (cmdBlocks == '0) ? DONE : REQ;
            REQ:   if (grant) stateNext = FETCH;
            FETCH: if (grant) begin
                       if (bus.dev_valid) stateNext = WRITE;
                       else if (timeout)  stateNext = DONE;
                   end
            WRITE: if (grant && lastLat) stateNext = NEXT;
            NEXT:  if (grant) begin
                       if (remain == 17'd1) stateNext = DONE;
`ifdef DMA_CYCLE_STEAL_EN
                       else                 stateNext = REL;
`else
                       else                 stateNext = FETCH;
`endif
                   end
            DONE:  stateNext = IDLE;
            REL:   stateNext = REQ;
            default: stateNext = IDLE;
        endcase
    end

    // Loss of grant freezes progress; a frozen WRITE restarts its latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            brQ     <= 1'b0;
            addr    <= '0;
            remain  <= '0;
            cnt     <= '0;
            block   <= '0;
            errFlag <= 1'b0;
        end else begin
            brQ <= stateNext inside {REQ, FETCH, WRITE, NEXT};
            unique case (state)
                IDLE: if (bus.cmd_valid) begin
                    addr    <= bus.cmd_addr & 16'hFFFC;
                    remain  <= cmdBlocks;
                    errFlag <= 1'b0;
                    cnt     <= '0;
                end
                REQ: cnt <= '0;
                FETCH: if (grant) begin
                    if (bus.dev_valid) begin
                        block <= bus.dev_data;
                        cnt   <= '0;
                    end else if (timeout) begin
                        errFlag <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WRITE: begin
                    if (!grant || lastLat) cnt <= '0;
                    else                   cnt <= cnt + 16'd1;
                end
                NEXT: if (grant) begin
                    addr   <= addr + 16'd4;
                    remain <= remain - 17'd1;
                    cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.BR      = brQ;
    assign bus.dev_req = grant && (state == FETCH);
    assign bus.busy    = (state != IDLE);
    assign bus.dma_end = (state == DONE);
    assign bus.dma_err = (state == DONE) && errFlag;
    assign writeM      = own && (cnt == '0);
    assign addressM    = own ? addr  : {16{1'bz}};
    assign dataM       = own ? block : {64{1'bz}};
endmodule

// File: tb/tb_dma_block_controller.sv
// tb_dma_block_controller: randomized bench with a cycle-level transfer
// model driving the CPU/device side and checking every output each cycle.
module tb_dma_block_controller;
  localparam int LAT = 4;
  localparam int TO  = 10;
`ifdef DMA_CYCLE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dma_block_controller_if bus ();
  logic       writeM;
  wire [15:0] addressM;
  wire [63:0] dataM;

  dma_block_controller #(
    .MEM_LAT(LAT),
    .DEV_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .writeM(writeM),
    .addressM(addressM),
    .dataM(dataM)
  );

  int checks = 0;
  int errors = 0;
  bit eBR, eBusy, eDreq, eWr, eDrv, eEnd, eErr;
  logic [15:0] eAddr = '0;
  logic [63:0] eData = '0;
  bit chkOn = 1'b0;

  logic [15:0] wlog[$];
  int brRises = 0;
  int ends = 0;
  int errs = 0;
  bit brPrev = 1'b0;
  int w0, r0, e0, x0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chkOn) begin
      chk("BR", 64'(bus.BR), 64'(eBR));
      chk("busy", 64'(bus.busy), 64'(eBusy));
      chk("dev_req", 64'(bus.dev_req), 64'(eDreq));
      chk("writeM", 64'(writeM), 64'(eWr));
      chk("dma_end", 64'(bus.dma_end), 64'(eEnd));
      chk("dma_err", 64'(bus.dma_err), 64'(eErr));
      if (eDrv) begin
        chk("addressM", 64'(addressM), 64'(eAddr));
        chk("dataM", dataM, eData);
      end
      if (bus.BR && !brPrev) brRises++;
      brPrev = bus.BR;
      if (writeM) wlog.push_back(addressM);
      if (bus.dma_end) ends++;
      if (bus.dma_err) errs++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    w0 = wlog.size();
    r0 = brRises;
    e0 = ends;
    x0 = errs;
  endtask

  // Expected outputs for this cycle; stray commands are thrown in while busy.
  task automatic setExp(input bit br, input bit busy, input bit dreq,
                        input bit wr, input bit drv, input bit en,
                        input bit er);
    eBR = br; eBusy = busy; eDreq = dreq; eWr = wr;
    eDrv = drv; eEnd = en; eErr = er;
    bus.dev_valid  = 1'b0;
    bus.cmd_valid  = busy && ($urandom_range(0, 9) == 0);
    bus.cmd_addr   = 16'($urandom);
    bus.cmd_length = 16'($urandom_range(0, 64));
  endtask

  task automatic grant(input int g);
    for (int i = 0; i < g; i++) begin
      setExp(1, 1, 0, 0, 0, 0, 0);
      bus.BG = 1'b0;
      step();
    end
    setExp(1, 1, 0, 0, 0, 0, 0);
    bus.BG = 1'b1;
    step();
  endtask

  task automatic xfer(input logic [15:0] a, input logic [15:0] len,
                      input int g, input int dlo, input int dhi,
                      input int dropAt);
    int n, d, j;
    logic [15:0] addr;
    bit err, dropped;
    n = (int'(len) + 3) / 4;
    addr = a & 16'hFFFC;
    err = 1'b0;
    dropped = 1'b0;
    setExp(0, 0, 0, 0, 0, 0, 0);
    bus.BG = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = a;
    bus.cmd_length = len;
    step();
    for (int b = 0; b < n; b++) begin
      if (b == 0 || STEAL) grant(g);
      d = int'($urandom_range(dhi, dlo));
      for (int k = 0; k < TO; k++) begin
        setExp(1, 1, 1, 0, 0, 0, 0);
        bus.BG = 1'b1;
        bus.dev_data = {$urandom, $urandom};
        if (k == d) begin
          bus.dev_valid = 1'b1;
          eData = bus.dev_data;
        end
        step();
        if (k == d) break;
      end
      if (d >= TO) begin
        err = 1'b1;
        break;
      end
      eAddr = addr;
      j = 0;
      while (j < LAT) begin
        if (b == 0 && j == dropAt && !dropped) begin
          dropped = 1'b1;
          repeat (3) begin
            setExp(1, 1, 0, 0, 0, 0, 0);
            bus.BG = 1'b0;
            step();
          end
          j = 0;
        end else begin
          setExp(1, 1, 0, j == 0, 1, 0, 0);
          bus.BG = 1'b1;
          step();
          j++;
        end
      end
      setExp(1, 1, 0, 0, 0, 0, 0);
      bus.BG = 1'b1;
      step();
      addr = addr + 16'd4;
      if (STEAL && b < n - 1) begin
        setExp(0, 1, 0, 0, 0, 0, 0);
        bus.BG = 1'b0;
        step();
      end
    end
    setExp(0, 1, 0, 0, 0, 1, err);
    bus.BG = 1'b0;
    step();
    setExp(0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic resetMidBurst();
    setExp(0, 0, 0, 0, 0, 0, 0);
    bus.BG = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 16'h0200;
    bus.cmd_length = 16'd16;
    step();
    grant(0);
    setExp(1, 1, 1, 0, 0, 0, 0);
    bus.BG = 1'b1;
    bus.dev_valid = 1'b1;
    bus.dev_data = 64'h0123_4567_89AB_CDEF;
    eData = bus.dev_data;
    step();
    eAddr = 16'h0200;
    setExp(1, 1, 0, 1, 1, 0, 0);
    step();
    setExp(1, 1, 0, 0, 1, 0, 0);
    step();
    setExp(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    bus.BG = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    repeat (6) begin
      setExp(0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    bus.BG = 1'b0;
    bus.dev_data = '0;
    setExp(0, 0, 0, 0, 0, 0, 0);
    chkOn = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    setExp(0, 0, 0, 0, 0, 0, 0);
    step();

    snap();
    xfer(16'h0013, 16'd8, 2, 0, 0, -1);
    chk("burst_nwr", 64'(wlog.size() - w0), 64'd2);
    chk("burst_a0", 64'(wlog[w0]), 64'h0010);
    chk("burst_a1", 64'(wlog[w0 + 1]), 64'h0014);
    chk("burst_br", 64'(brRises - r0), STEAL ? 64'd2 : 64'd1);
    chk("burst_end", 64'(ends - e0), 64'd1);

    snap();
    xfer(16'h0400, 16'd0, 1, 0, 0, -1);
    chk("len0_br", 64'(brRises - r0), 64'd0);
    chk("len0_end", 64'(ends - e0), 64'd1);
    chk("len0_nwr", 64'(wlog.size() - w0), 64'd0);

    snap();
    xfer(16'h0020, 16'd5, 1, 0, 3, -1);
    chk("len5_nwr", 64'(wlog.size() - w0), 64'd2);

    snap();
    xfer(16'hFFFC, 16'd8, 0, 0, 2, -1);
    chk("wrap_a0", 64'(wlog[w0]), 64'hFFFC);
    chk("wrap_a1", 64'(wlog[w0 + 1]), 64'h0000);

    snap();
    xfer(16'h0040, 16'd8, 1, TO, TO, -1);
    chk("to_end", 64'(ends - e0), 64'd1);
    chk("to_err", 64'(errs - x0), 64'd1);
    chk("to_nwr", 64'(wlog.size() - w0), 64'd0);

    snap();
    xfer(16'h0100, 16'd8, 0, 0, 2, 1);
    chk("drop_nwr", 64'(wlog.size() - w0), 64'd3);
    chk("drop_a0", 64'(wlog[w0]), 64'h0100);
    chk("drop_a1", 64'(wlog[w0 + 1]), 64'h0100);
    chk("drop_a2", 64'(wlog[w0 + 2]), 64'h0104);

    snap();
    xfer(16'h0800, 16'd12, 1, 0, 1, -1);
    chk("len12_br", 64'(brRises - r0), STEAL ? 64'd3 : 64'd1);
    chk("len12_nwr", 64'(wlog.size() - w0), 64'd3);

    snap();
    resetMidBurst();
    chk("rst_end", 64'(ends - e0), 64'd0);
    chk("rst_nwr", 64'(wlog.size() - w0), 64'd1);

    for (int t = 0; t < 40; t++) begin
      int dropAt;
      dropAt = int'($urandom_range(0, 7));
      if (dropAt > 3) dropAt = -1;
      xfer(16'($urandom), 16'($urandom_range(0, 40)),
           int'($urandom_range(0, 3)), 0, 11, dropAt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
